// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencer:
//   - default widths and reset PC
//   - sequencer state encoding
//   - sext(): sign-extends a narrow two's-complement field held in the low
//     bits of a 32-bit word (valid for field widths 1..32)
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int PC_W_DEF  = 16;
    localparam int OFF_W_DEF = 9;
    localparam int CNT_W_DEF = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    // Shift the field's sign bit up to bit 31, then arithmetic-shift back down.
    function automatic logic [31:0] sext(input logic [31:0] val, input int unsigned w);
        logic [31:0] sh_s;
        int unsigned amt_s;
        amt_s = 32'd32 - w;
        sh_s  = val << amt_s;
        return $signed(sh_s) >>> amt_s;
    endfunction

endpackage

// File: rtl/pc_target_adder.sv
// -----------------------------------------------------------------------------
// pc_target_adder
// Combinational next-PC computation: pc + 1, plus the sign-extended offset
// when take_i is set. All sums wrap modulo 2^PC_W. Requires OFF_W <= PC_W <= 32.
// Ports:
//   pc_i       current PC
//   offset_i   two's-complement PC-relative offset
//   take_i     1 = add offset (branch), 0 = sequential
//   next_pc_o  resulting PC
// -----------------------------------------------------------------------------
module pc_target_adder
    import pc_seq_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic [PC_W-1:0]  pc_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic             take_i,
    output logic [PC_W-1:0]  next_pc_o
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] off_ext_s;

    // Sign-extend the offset and form the wrapped target address.
    always_comb begin
        off_ext_s = PC_W'(sext(32'(offset_i), OFF_W));
        next_pc_o = pc_i + PC_ONE + (take_i ? off_ext_s : {PC_W{1'b0}});
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer between the ALU/branch FSM and instruction memory.
// All state updates on the falling edge of clka; reset_in is synchronous,
// active-high and overrides every other input.
// Ports:
//   clka              clock (falling-edge active)
//   reset_in          synchronous active-high reset
//   pc_latch_in       FSM PC-phase level; its rising transition is the update event
//   pc_ctl_0_in       1 = branch taken, 0 = sequential
//   br_off_in         signed PC-relative branch offset
//   halt_in           current instruction is HALT
//   pc_out            current instruction address
//   npc_out           pc_out + 1 (combinational, wraps)
//   fetch_strobe_out  one-cycle pulse when pc_out holds a new address to fetch
//   halted_out        sequencer is halted
//   instr_count_out   retired-instruction count, saturating
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              OFF_W    = OFF_W_DEF,
    parameter int              CNT_W    = CNT_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic              clka,
    input  logic              reset_in,
    input  logic              pc_latch_in,
    input  logic              pc_ctl_0_in,
    input  logic [OFF_W-1:0]  br_off_in,
    input  logic              halt_in,
    output logic [PC_W-1:0]   pc_out,
    output logic [PC_W-1:0]   npc_out,
    output logic              fetch_strobe_out,
    output logic              halted_out,
    output logic [CNT_W-1:0]  instr_count_out
);

    seq_state_e       state_q, state_d;
    logic             latch_q;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             strobe_q, strobe_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             ev_s;
    logic [CNT_W-1:0] count_inc_s;
    logic [PC_W-1:0]  next_pc_s;

    pc_target_adder #(.PC_W(PC_W), .OFF_W(OFF_W)) u_target (
        .pc_i      (pc_q),
        .offset_i  (br_off_in),
        .take_i    (pc_ctl_0_in),
        .next_pc_o (next_pc_s)
    );

    pc_target_adder #(.PC_W(PC_W), .OFF_W(OFF_W)) u_npc (
        .pc_i      (pc_q),
        .offset_i  ({OFF_W{1'b0}}),
        .take_i    (1'b0),
        .next_pc_o (npc_out)
    );

    // Update event is the rising transition of the PC-latch level; latch_q
    // resets to 1 so a level held high through reset does not count.
    assign ev_s        = pc_latch_in & ~latch_q;
    assign count_inc_s = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

    // Next-state and output logic of the BOOT/RUN/HALT sequencer.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        strobe_d = 1'b0;
        halted_d = halted_q;
        count_d  = count_q;
        case (state_q)
            ST_BOOT: begin
                // Single cycle: fetch the reset PC, discard any event.
                strobe_d = 1'b1;
                halted_d = 1'b0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (ev_s) begin
                    count_d = count_inc_s;
                    if (halt_in) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d     = next_pc_s;
                        strobe_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d  = ST_BOOT;
                halted_d = 1'b0;
            end
        endcase
    end

    // State and output registers, falling-edge with synchronous reset.
    always_ff @(negedge clka) begin
        if (reset_in) begin
            state_q  <= ST_BOOT;
            latch_q  <= 1'b1;
            pc_q     <= RESET_PC;
            strobe_q <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            latch_q  <= pc_latch_in;
            pc_q     <= pc_d;
            strobe_q <= strobe_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign pc_out           = pc_q;
    assign fetch_strobe_out = strobe_q;
    assign halted_out       = halted_q;
    assign instr_count_out  = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Scoreboard bench: the driver feeds a behavioural model that pushes expected
// fetch and halt responses into queues; a monitor pops them when the DUT
// strobes or enters HALT. A second instance with a 4-bit counter shares the
// stimulus to observe counter saturation.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clka;
    logic        reset_in;
    logic        pc_latch_in;
    logic        pc_ctl_0_in;
    logic [8:0]  br_off_in;
    logic        halt_in;

    logic [15:0] pc_out, npc_out, instr_count_out;
    logic        fetch_strobe_out, halted_out;
    logic [15:0] pc4_out, npc4_out;
    logic [3:0]  cnt4_out;
    logic        strobe4_out, halted4_out;

    pc_sequencer #(.PC_W(16), .OFF_W(9), .CNT_W(16), .RESET_PC(16'h0000)) dut (
        .clka             (clka),
        .reset_in         (reset_in),
        .pc_latch_in      (pc_latch_in),
        .pc_ctl_0_in      (pc_ctl_0_in),
        .br_off_in        (br_off_in),
        .halt_in          (halt_in),
        .pc_out           (pc_out),
        .npc_out          (npc_out),
        .fetch_strobe_out (fetch_strobe_out),
        .halted_out       (halted_out),
        .instr_count_out  (instr_count_out)
    );

    pc_sequencer #(.PC_W(16), .OFF_W(9), .CNT_W(4), .RESET_PC(16'h0000)) dut4 (
        .clka             (clka),
        .reset_in         (reset_in),
        .pc_latch_in      (pc_latch_in),
        .pc_ctl_0_in      (pc_ctl_0_in),
        .br_off_in        (br_off_in),
        .halt_in          (halt_in),
        .pc_out           (pc4_out),
        .npc_out          (npc4_out),
        .fetch_strobe_out (strobe4_out),
        .halted_out       (halted4_out),
        .instr_count_out  (cnt4_out)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    typedef struct {
        int pc;
        int cnt;
        int cnt4;
    } exp_t;

    exp_t sq[$];   // expected responses at fetch strobes
    exp_t hq[$];   // expected responses at HALT entry

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
    int m_mode = M_BOOT;
    bit m_prev = 1'b1;
    int m_pc = 0, m_cnt = 0, m_cnt4 = 0;

    task automatic model_step(input bit rst, input bit lat, input bit ctl,
                              input logic [8:0] off, input bit hlt);
        bit ev;
        int delta;
        if (rst) begin
            m_mode = M_BOOT; m_prev = 1'b1; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            ev = lat && !m_prev;
            m_prev = lat;
            if (m_mode == M_BOOT) begin
                sq.push_back('{m_pc, m_cnt, m_cnt4});
                m_mode = M_RUN;
            end else if (m_mode == M_RUN && ev) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
                m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
                if (hlt) begin
                    m_mode = M_HALT;
                    hq.push_back('{m_pc, m_cnt, m_cnt4});
                end else begin
                    delta = 0;
                    if (ctl) delta = (int'(off) >= 256) ? int'(off) - 512 : int'(off);
                    m_pc = (m_pc + 1 + delta) & 32'h0000FFFF;
                    sq.push_back('{m_pc, m_cnt, m_cnt4});
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit lat, input bit ctl,
                        input logic [8:0] off, input bit hlt);
        @(posedge clka);
        reset_in    = rst;
        pc_latch_in = lat;
        pc_ctl_0_in = ctl;
        br_off_in   = off;
        halt_in     = hlt;
        model_step(rst, lat, ctl, off, hlt);
        @(negedge clka);
        #1;
    endtask

    task automatic rstep(input bit rst, input bit lat);
        step(rst, lat, 1'($urandom), 9'($urandom), 1'($urandom));
    endtask

    task automatic pulse(input bit ctl, input logic [8:0] off, input bit hlt);
        int hold, low;
        hold = $urandom_range(0, 2);
        low  = $urandom_range(1, 2);
        step(1'b0, 1'b1, ctl, off, hlt);
        for (int i = 0; i < hold; i++) rstep(1'b0, 1'b1);
        for (int i = 0; i < low; i++)  rstep(1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    logic mon_prev_h = 1'b0;
    int   fz_pc, fz_cnt;

    always @(posedge clka) begin
        if (fetch_strobe_out === 1'b1) begin
            if (sq.size() == 0) begin
                chk("stray_strobe", 32'(fetch_strobe_out), 32'd0);
            end else begin
                mon_e = sq.pop_front();
                chk("strobe_pc",     32'(pc_out),          mon_e.pc);
                chk("strobe_npc",    32'(npc_out),         (mon_e.pc + 1) & 32'h0000FFFF);
                chk("strobe_cnt",    32'(instr_count_out), mon_e.cnt);
                chk("strobe_cnt4",   32'(cnt4_out),        mon_e.cnt4);
                chk("strobe_pc4",    32'(pc4_out),         mon_e.pc);
                chk("strobe4",       32'(strobe4_out),     32'd1);
                chk("strobe_halted", 32'(halted_out),      32'd0);
            end
        end
        if (halted_out === 1'b1 && mon_prev_h !== 1'b1) begin
            if (hq.size() == 0) begin
                chk("stray_halt", 32'(halted_out), 32'd0);
            end else begin
                mon_e = hq.pop_front();
                fz_pc  = mon_e.pc;
                fz_cnt = mon_e.cnt;
                chk("halt_pc",      32'(pc_out),          mon_e.pc);
                chk("halt_cnt",     32'(instr_count_out), mon_e.cnt);
                chk("halt_cnt4",    32'(cnt4_out),        mon_e.cnt4);
                chk("halt4",        32'(halted4_out),     32'd1);
                chk("halt_strobe",  32'(fetch_strobe_out), 32'd0);
            end
        end else if (halted_out === 1'b1) begin
            chk("frozen_pc",     32'(pc_out),           fz_pc);
            chk("frozen_cnt",    32'(instr_count_out),  fz_cnt);
            chk("frozen_strobe", 32'(fetch_strobe_out), 32'd0);
        end
        mon_prev_h = halted_out;
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_in = 1'b1; pc_latch_in = 1'b1; pc_ctl_0_in = 1'b0;
        br_off_in = 9'd0; halt_in = 1'b0;

        // Reset with the latch level held high.
        repeat (3) step(1'b1, 1'b1, 1'b0, 9'd0, 1'b0);
        chk("rst_pc",     32'(pc_out),           32'h0000);
        chk("rst_strobe", 32'(fetch_strobe_out), 32'd0);
        chk("rst_halted", 32'(halted_out),       32'd0);
        chk("rst_cnt",    32'(instr_count_out),  32'd0);

        // Release with latch still high: only the BOOT fetch.
        repeat (5) rstep(1'b0, 1'b1);
        chk("boot_pc",  32'(pc_out),          32'h0000);
        chk("boot_cnt", 32'(instr_count_out), 32'd0);
        rstep(1'b0, 1'b0);

        // Three sequential updates.
        repeat (3) pulse(1'b0, 9'($urandom), 1'b0);
        chk("seq3_pc",  32'(pc_out),          32'h0003);
        chk("seq3_cnt", 32'(instr_count_out), 32'd3);

        // Branches, including a negative offset and wrap below zero.
        pulse(1'b1, 9'd12, 1'b0);
        chk("br_to_10", 32'(pc_out), 32'h0010);
        pulse(1'b1, 9'h1F0, 1'b0);
        chk("br_m16",   32'(pc_out), 32'h0001);
        pulse(1'b1, 9'h1FD, 1'b0);
        chk("br_wrap",  32'(pc_out), 32'hFFFF);
        pulse(1'b0, 9'($urandom), 1'b0);
        chk("seq_wrap", 32'(pc_out), 32'h0000);

        // Random traffic; pushes the 4-bit counter into saturation.
        repeat (25) pulse(1'($urandom), 9'($urandom), 1'b0);
        chk("rand_pc",   32'(pc_out),          m_pc);
        chk("rand_cnt",  32'(instr_count_out), m_cnt);
        chk("cnt4_sat",  32'(cnt4_out),        32'hF);

        // Reset on the same edge as an update event.
        step(1'b1, 1'b1, 1'b1, 9'($urandom), 1'b0);
        chk("rstev_pc",     32'(pc_out),           32'h0000);
        chk("rstev_strobe", 32'(fetch_strobe_out), 32'd0);
        chk("rstev_cnt",    32'(instr_count_out),  32'd0);
        repeat (2) rstep(1'b0, 1'b1);
        rstep(1'b0, 1'b0);

        // HALT at pc 5, then pulses that must have no effect.
        pulse(1'b1, 9'd4, 1'b0);
        chk("pre_halt_pc", 32'(pc_out), 32'h0005);
        pulse(1'($urandom), 9'($urandom), 1'b1);
        chk("halted",     32'(halted_out),      32'd1);
        chk("halt_pc5",   32'(pc_out),          32'h0005);
        chk("halt_cnt2",  32'(instr_count_out), 32'd2);
        repeat (4) pulse(1'($urandom), 9'($urandom), 1'($urandom));
        chk("post_halt_pc",  32'(pc_out),          32'h0005);
        chk("post_halt_cnt", 32'(instr_count_out), 32'd2);

        // Reset leaves HALT.
        repeat (2) step(1'b1, 1'b1, 1'b0, 9'd0, 1'b0);
        chk("unhalt",    32'(halted_out), 32'd0);
        chk("unhalt_pc", 32'(pc_out),     32'h0000);
        rstep(1'b0, 1'b1);
        rstep(1'b0, 1'b0);
        pulse(1'b0, 9'($urandom), 1'b0);
        chk("rerun_pc", 32'(pc_out), 32'h0001);

        repeat (3) rstep(1'b0, 1'b0);
        chk("sq_drained", 32'(sq.size()), 32'd0);
        chk("hq_drained", 32'(hq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
